// File: rtl/fetch_pkg.sv
// Shared types and the address legality check for the instruction-fetch block.
package fetch_pkg;
    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;

    typedef enum logic [1:0] {IDLE, FETCH, FAULT} fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // A fetch is illegal when misaligned or when its last byte falls outside the ROM.
    // The sum is widened by one bit so addresses near 2^64 cannot wrap into range.
    function automatic logic addr_bad(input logic [ADDR_W-1:0] addr,
                                      input logic [ADDR_W-1:0] mem_size);
        logic [ADDR_W:0] last;
        last = {1'b0, addr} + (ADDR_W+1)'(3);
        return (addr[1:0] != 2'b00) || (last >= {1'b0, mem_size});
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Small pointer-based FIFO of {pc, instr} entries; flush wins over push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t din_i,
    output logic         full_o,
    output logic         empty_o,
    output fetch_entry_t head_o
);
    localparam int PW = $clog2(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [PW:0]   cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop_i) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
        end
    end

    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_q];
endmodule

// File: rtl/fetch_sequencer.sv
// Owns the PC, reads the combinational ROM, and queues {pc, instr} toward decode.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned       MEM_SIZE = 1024,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                DEPTH    = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               run,
    output logic [ADDR_W-1:0]  imem_address,
    input  logic [INSTR_W-1:0] imem_instruction,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               fault
);
    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              fault_q;
    logic              push, pop, full, empty, pc_bad, tgt_bad;
    fetch_entry_t      head, wdata;

    assign pc_bad  = addr_bad(pc_q, ADDR_W'(MEM_SIZE));
    assign tgt_bad = addr_bad(redirect_target, ADDR_W'(MEM_SIZE));

    // The head is hidden during a redirect so a same-cycle pop cannot consume a stale entry.
    assign out_valid = ~empty & ~redirect_valid;
    assign pop       = out_valid & out_ready;
    assign push      = (state_q == FETCH) & run & ~redirect_valid & ~pc_bad & (~full | pop);
    assign wdata     = '{pc: pc_q, instr: imem_instruction};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_target;
            if (tgt_bad)                       state_d = FAULT;
            else if (state_q == FAULT)         state_d = FETCH;
            else if (state_q == FETCH && !run) state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:  if (run) state_d = FETCH;
                FETCH: begin
                    if (!run)        state_d = IDLE;
                    else if (pc_bad) state_d = FAULT;
                    else if (push)   pc_d = pc_q + ADDR_W'(4);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= (state_d == FAULT);
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .din_i   (wdata),
        .full_o  (full),
        .empty_o (empty),
        .head_o  (head)
    );

    assign imem_address = pc_q;
    assign out_instr    = head.instr;
    assign out_pc       = head.pc;
    assign fault        = fault_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: fixed vector table, directed corner sequences, and random
// traffic checked each cycle against a queue-based reference model.
module tb_fetch_sequencer;
    localparam int unsigned MEM_SIZE = 1024;
    localparam logic [63:0] RESET_PC = 64'd0;
    localparam int          DEPTH    = 2;
    localparam int M_IDLE = 0, M_FETCH = 1, M_FAULT = 2;

    logic        clk = 1'b0;
    logic        reset_n, run, redirect_valid, out_ready, out_valid, fault;
    logic [63:0] redirect_target, imem_address, out_pc;
    logic [31:0] imem_instruction, out_instr;

    int checks = 0;
    int failures = 0;

    // reference model state
    int          m_mode;
    logic [63:0] m_pc;
    logic [63:0] q[$];

    // values sampled by the most recent step
    logic        s_valid, s_fault;
    logic [63:0] s_pc, s_addr;

    typedef struct {
        bit          rst;
        bit          run;
        bit          rdy;
        bit          ev;
        logic [63:0] epc;
        logic [63:0] eaddr;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    assign imem_instruction = rom(imem_address);

    fetch_sequencer #(.MEM_SIZE(MEM_SIZE), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .run              (run),
        .imem_address     (imem_address),
        .imem_instruction (imem_instruction),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_instr        (out_instr),
        .out_pc           (out_pc),
        .fault            (fault)
    );

    function automatic vec_t V(bit rs, bit r, bit y, bit v, int pc, int ad);
        vec_t t;
        t.rst = rs; t.run = r; t.rdy = y; t.ev = v;
        t.epc = 64'(pc); t.eaddr = 64'(ad);
        return t;
    endfunction

    function automatic bit m_bad(input logic [63:0] a);
        return (a[1:0] != 2'b00) || (a > 64'(MEM_SIZE) - 64'd4);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_mode = M_IDLE;
        m_pc   = RESET_PC;
        q.delete();
    endtask

    task automatic m_step(input logic r, input logic rv, input logic [63:0] tgt,
                          input logic rdy, input logic v);
        if (v && rdy) q.delete(0);
        if (rv) begin
            q.delete();
            m_pc = tgt;
            if (m_bad(tgt))                  m_mode = M_FAULT;
            else if (m_mode == M_FAULT)      m_mode = M_FETCH;
            else if (m_mode == M_FETCH && !r) m_mode = M_IDLE;
        end else if (m_mode == M_IDLE) begin
            if (r) m_mode = M_FETCH;
        end else if (m_mode == M_FETCH) begin
            if (!r)               m_mode = M_IDLE;
            else if (m_bad(m_pc)) m_mode = M_FAULT;
            else if (q.size() < DEPTH) begin
                q.push_back(m_pc);
                m_pc = m_pc + 64'd4;
            end
        end
    endtask

    // Entered just after a rising edge; drives inputs, checks on the falling edge,
    // then advances the model across the next rising edge.
    task automatic step(input logic r, input logic rv, input logic [63:0] tgt, input logic rdy);
        logic mv;
        run = r; redirect_valid = rv; redirect_target = tgt; out_ready = rdy;
        @(negedge clk);
        mv = (q.size() > 0) && !rv;
        s_valid = out_valid; s_pc = out_pc; s_addr = imem_address; s_fault = fault;
        chk("out_valid", out_valid, mv);
        chk("imem_address", imem_address, m_pc);
        chk("fault", fault, m_mode == M_FAULT);
        if (mv) begin
            chk("out_pc", out_pc, q[0]);
            chk("out_instr", out_instr, rom(q[0]));
        end
        @(posedge clk);
        m_step(r, rv, tgt, rdy, mv);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; run = 1'b0; redirect_valid = 1'b0;
        redirect_target = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_instr", out_instr, 0);
        chk("rst_fault", fault, 0);
        chk("rst_addr", imem_address, RESET_PC);
        m_reset();
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_tbl(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if (tbl[i].rst) do_reset();
            step(tbl[i].run, 1'b0, 64'd0, tbl[i].rdy);
            chk("tbl_valid", s_valid, tbl[i].ev);
            if (tbl[i].ev) chk("tbl_pc", s_pc, tbl[i].epc);
            chk("tbl_addr", s_addr, tbl[i].eaddr);
        end
    endtask

    initial begin
        // startup, 1 instruction/cycle
        tbl.push_back(V(1, 1, 1, 0, 0, 0));
        tbl.push_back(V(0, 1, 1, 0, 0, 0));
        tbl.push_back(V(0, 1, 1, 1, 0, 4));
        tbl.push_back(V(0, 1, 1, 1, 4, 8));
        tbl.push_back(V(0, 1, 1, 1, 8, 12));
        tbl.push_back(V(0, 1, 1, 1, 12, 16));
        // backpressure: FIFO fills with 0,4 and the pc parks at 8
        tbl.push_back(V(1, 1, 0, 0, 0, 0));
        tbl.push_back(V(0, 1, 0, 0, 0, 0));
        tbl.push_back(V(0, 1, 0, 1, 0, 4));
        tbl.push_back(V(0, 1, 0, 1, 0, 8));
        tbl.push_back(V(0, 1, 0, 1, 0, 8));
        tbl.push_back(V(0, 1, 0, 1, 0, 8));
        tbl.push_back(V(0, 1, 1, 1, 0, 8));
        tbl.push_back(V(0, 1, 1, 1, 4, 12));
        tbl.push_back(V(0, 1, 1, 1, 8, 16));
        tbl.push_back(V(0, 1, 1, 1, 12, 20));

        m_reset();
        apply_tbl(0, tbl.size() - 1);

        // redirect while the FIFO is full
        do_reset();
        repeat (4) step(1, 0, 0, 0);
        step(1, 1, 64'h40, 1);
        chk("redir_gate", s_valid, 0);
        step(1, 0, 0, 1);
        chk("redir_n1_valid", s_valid, 0);
        chk("redir_n1_addr", s_addr, 64'h40);
        step(1, 0, 0, 1);
        chk("redir_n2_valid", s_valid, 1);
        chk("redir_n2_pc", s_pc, 64'h40);
        step(1, 0, 0, 1);
        chk("redir_n3_pc", s_pc, 64'h44);

        // end of memory
        step(1, 1, 64'd1020, 1);
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        chk("eom_valid", s_valid, 1);
        chk("eom_pc", s_pc, 64'd1020);
        chk("eom_addr", s_addr, 64'd1024);
        step(1, 0, 0, 1);
        chk("eom_fault", s_fault, 1);
        chk("eom_nopush", s_valid, 0);
        chk("eom_hold", s_addr, 64'd1024);
        repeat (2) step(1, 0, 0, 1);
        chk("eom_hold2", s_addr, 64'd1024);

        // misaligned redirect, then recovery
        do_reset();
        repeat (3) step(1, 0, 0, 1);
        step(1, 1, 64'h42, 1);
        step(1, 0, 0, 1);
        chk("bad_fault", s_fault, 1);
        chk("bad_addr", s_addr, 64'h42);
        chk("bad_nopush", s_valid, 0);
        step(1, 0, 0, 1);
        step(1, 1, 64'h10, 1);
        chk("rec_fault_still", s_fault, 1);
        step(1, 0, 0, 1);
        chk("rec_fault_clear", s_fault, 0);
        step(1, 0, 0, 1);
        chk("rec_valid", s_valid, 1);
        chk("rec_pc", s_pc, 64'h10);

        // asynchronous reset between edges with entries queued
        do_reset();
        repeat (4) step(1, 0, 0, 0);
        #2;
        chk("pre_async_valid", out_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("async_valid", out_valid, 0);
        chk("async_addr", imem_address, RESET_PC);
        chk("async_fault", fault, 0);
        m_reset();
        apply_tbl(0, 5);

        // random traffic against the model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            logic [63:0] tgt;
            case ($urandom_range(0, 4))
                0: tgt = 64'($urandom_range(0, 255)) << 2;
                1: tgt = 64'(MEM_SIZE) - 64'($urandom_range(0, 3)) * 64'd4;
                2: tgt = 64'($urandom_range(0, 1023));
                3: tgt = 64'hFFFF_FFFF_FFFF_FFFC;
                default: tgt = 64'd1020;
            endcase
            step($urandom_range(0, 9) != 0, $urandom_range(0, 11) == 0, tgt,
                 $urandom_range(0, 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
